// File: rtl/micro_core_param.sv
// Parametrised accumulator/register-file core with valid/ready instruction, input and output ports.
// An instruction is latched in IDLE and executes in EXEC once its source and destination are available.
module micro_core_param #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [2:0]        inst_op,
    input  logic [SEL_W-1:0]  inst_dst,
    input  logic [SEL_W-1:0]  inst_src,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] acc_out,
    output logic              flag_c,
    output logic              flag_z,
    output logic              busy
);
    typedef enum logic {S_IDLE, S_EXEC} state_e;
    typedef enum logic [2:0] {
        OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADC, OP_NOP
    } op_e;

    state_e             state_q, state_d;
    op_e                ir_op_q, ir_op_d;
    logic [SEL_W-1:0]   ir_dst_q, ir_dst_d, ir_src_q, ir_src_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  gp_q [2:NUM_REGS-1];
    logic [DATA_W-1:0]  gp_d [2:NUM_REGS-1];
    logic               c_q, c_d, z_q, z_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;

    logic               exec, is_nop, src_ok, dst_ok, fire, upd_flags, c_new;
    logic [DATA_W-1:0]  src_val, res;
    logic [DATA_W:0]    sum, diff;

    assign exec    = (state_q == S_EXEC);
    assign is_nop  = (ir_op_q == OP_NOP);
    assign src_ok  = (ir_src_q != '0) | in_valid;
    assign dst_ok  = (ir_dst_q != '0) | !out_valid_q | out_ready;
    // in_ready looks only at IR and the output register, never at in_valid.
    assign in_ready = exec & !is_nop & (ir_src_q == '0) & dst_ok;
    assign fire     = exec & (is_nop | (src_ok & dst_ok));

    // Indices beyond NUM_REGS-1 fall through and read as zero.
    always_comb begin
        src_val = '0;
        if (ir_src_q == SEL_W'(0)) begin
            src_val = in_data;
        end else if (ir_src_q == SEL_W'(1)) begin
            src_val = a_q;
        end else begin
            for (int i = 2; i < NUM_REGS; i++) begin
                if (ir_src_q == SEL_W'(i)) src_val = gp_q[i];
            end
        end
    end

    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, src_val} + {{DATA_W{1'b0}}, (ir_op_q == OP_ADC) & c_q};
        diff      = {1'b0, a_q} - {1'b0, src_val};
        res       = src_val;
        c_new     = c_q;
        upd_flags = 1'b1;
        case (ir_op_q)
            OP_ADD, OP_ADC: {c_new, res} = sum;
            OP_SUB:         {c_new, res} = diff;
            OP_AND:         begin res = a_q & src_val; c_new = 1'b0; end
            OP_OR:          begin res = a_q | src_val; c_new = 1'b0; end
            OP_XOR:         begin res = a_q ^ src_val; c_new = 1'b0; end
            default:        upd_flags = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ir_op_d     = ir_op_q;
        ir_dst_d    = ir_dst_q;
        ir_src_d    = ir_src_q;
        a_d         = a_q;
        gp_d        = gp_q;
        c_d         = c_q;
        z_d         = z_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (inst_valid) begin
                    ir_op_d  = op_e'(inst_op);
                    ir_dst_d = inst_dst;
                    ir_src_d = inst_src;
                    state_d  = S_EXEC;
                end
            end
            default: begin
                if (fire) begin
                    state_d = S_IDLE;
                    if (!is_nop) begin
                        if (upd_flags) begin
                            c_d = c_new;
                            z_d = (res == '0);
                        end
                        // A new write on a handshake edge keeps out_valid high with fresh data.
                        if (ir_dst_q == SEL_W'(0)) begin
                            out_data_d  = res;
                            out_valid_d = 1'b1;
                        end else if (ir_dst_q == SEL_W'(1)) begin
                            a_d = res;
                        end else begin
                            for (int i = 2; i < NUM_REGS; i++) begin
                                if (ir_dst_q == SEL_W'(i)) gp_d[i] = res;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ir_op_q     <= OP_MOV;
            ir_dst_q    <= '0;
            ir_src_q    <= '0;
            a_q         <= '0;
            for (int i = 2; i < NUM_REGS; i++) gp_q[i] <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_op_q     <= ir_op_d;
            ir_dst_q    <= ir_dst_d;
            ir_src_q    <= ir_src_d;
            a_q         <= a_d;
            for (int i = 2; i < NUM_REGS; i++) gp_q[i] <= gp_d[i];
            c_q         <= c_d;
            z_q         <= z_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign inst_ready = (state_q == S_IDLE);
    assign busy       = exec;
    assign acc_out    = a_q;
    assign flag_c     = c_q;
    assign flag_z     = z_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
endmodule

// File: tb/tb_micro_core_param.sv
// Bench for micro_core_param: an 8-bit/8-register core and a 12-bit/5-register core share
// the stimulus; cfg picks which one is checked against the arithmetic model.
module tb_micro_core_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic [2:0]  inst_op = '0, inst_dst = '0, inst_src = '0;
    logic [11:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    bit          cfg = 1'b0;

    logic        a_inst_ready, a_in_ready, a_out_valid, a_flag_c, a_flag_z, a_busy;
    logic [7:0]  a_out_data, a_acc;
    logic        b_inst_ready, b_in_ready, b_out_valid, b_flag_c, b_flag_z, b_busy;
    logic [11:0] b_out_data, b_acc;

    micro_core_param #(.DATA_W(8), .NUM_REGS(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(a_inst_ready),
        .inst_op(inst_op), .inst_dst(inst_dst), .inst_src(inst_src),
        .in_data(in_data[7:0]), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .acc_out(a_acc), .flag_c(a_flag_c), .flag_z(a_flag_z), .busy(a_busy)
    );

    micro_core_param #(.DATA_W(12), .NUM_REGS(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(b_inst_ready),
        .inst_op(inst_op), .inst_dst(inst_dst), .inst_src(inst_src),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .acc_out(b_acc), .flag_c(b_flag_c), .flag_z(b_flag_z), .busy(b_busy)
    );

    logic        m_inst_ready, m_in_ready, m_out_valid, m_flag_c, m_flag_z, m_busy;
    logic [11:0] m_out_data, m_acc;
    assign m_inst_ready = cfg ? b_inst_ready : a_inst_ready;
    assign m_in_ready   = cfg ? b_in_ready   : a_in_ready;
    assign m_out_valid  = cfg ? b_out_valid  : a_out_valid;
    assign m_flag_c     = cfg ? b_flag_c     : a_flag_c;
    assign m_flag_z     = cfg ? b_flag_z     : a_flag_z;
    assign m_busy       = cfg ? b_busy       : a_busy;
    assign m_out_data   = cfg ? b_out_data   : {4'h0, a_out_data};
    assign m_acc        = cfg ? b_acc        : {4'h0, a_acc};

    always #5 clk = ~clk;

    // Scoreboard and reference model state.
    int          n_pass = 0, n_total = 0;
    logic [11:0] exp_q[$];
    longint      m_regs[16];
    longint      m_c, m_z, m_mask;
    int          m_nregs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    endtask

    function automatic void model_reset();
        foreach (m_regs[i]) m_regs[i] = 0;
        m_c = 0;
        m_z = 0;
        exp_q.delete();
    endfunction

    // Architectural effect of one completed instruction, straight from the op table.
    function automatic void model_apply(int op, int dst, int src, longint sval);
        longint a, s, r;
        a = m_regs[1];
        s = (src == 0) ? sval : ((src < m_nregs) ? m_regs[src] : 0);
        r = 0;
        case (op)
            0: r = s;
            1: begin r = a + s;       m_c = (r > m_mask) ? 1 : 0; end
            2: begin r = a - s;       m_c = (a < s) ? 1 : 0;      end
            3: begin r = a & s;       m_c = 0; end
            4: begin r = a | s;       m_c = 0; end
            5: begin r = a ^ s;       m_c = 0; end
            6: begin r = a + s + m_c; m_c = (r > m_mask) ? 1 : 0; end
            default: return;
        endcase
        r = r & m_mask;
        if (op != 0) m_z = (r == 0) ? 1 : 0;
        if (dst == 0) exp_q.push_back(r[11:0]);
        else if (dst < m_nregs) m_regs[dst] = r;
    endfunction

    // Output monitor: every accepted beat must match the model, and data must hold under backpressure.
    bit          hold_prev = 1'b0;
    logic [11:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) check("out_hold", {m_out_valid, m_out_data}, {1'b1, prev_data});
            if (m_out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_extra_beat", 1, 0);
                else check("out_beat", m_out_data, exp_q.pop_front());
            end
            hold_prev = m_out_valid && !out_ready;
            prev_data = m_out_data;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        inst_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_acc", m_acc, 0);
        check("rst_flags", {m_flag_c, m_flag_z}, 0);
        check("rst_out", {m_out_valid, m_out_data}, 0);
        check("rst_ready_busy", {m_inst_ready, m_busy, m_in_ready}, 3'b100);
    endtask

    // Called just after a rising edge with the core in IDLE. out_hold<0 randomises out_ready,
    // otherwise out_ready stays low for the first out_hold EXEC cycles.
    task automatic run_inst(input int op, input int dst, input int src, input longint data,
                            input int in_delay, input int out_hold);
        int cyc, hs;
        bit done;
        check("issue_ready", m_inst_ready, 1);
        inst_valid = 1'b1;
        inst_op = 3'(op);
        inst_dst = 3'(dst);
        inst_src = 3'(src);
        in_data = 12'(data & m_mask);
        in_valid = (in_delay == 0);
        out_ready = (out_hold < 0) ? 1'($urandom_range(0, 1)) : (out_hold == 0);
        @(posedge clk);
        #1 inst_valid = 1'b0;
        cyc = 0;
        hs = 0;
        done = 1'b0;
        while (!done && cyc < 64) begin
            check("exec_busy", {m_busy, m_inst_ready}, 2'b10);
            check("exec_hold", {m_acc, m_flag_c, m_flag_z},
                  {m_regs[1][11:0], m_c[0], m_z[0]});
            in_valid = (cyc >= in_delay);
            out_ready = (out_hold < 0) ? 1'($urandom_range(0, 1)) : (cyc >= out_hold);
            @(negedge clk);
            if (m_in_ready && in_valid) hs++;
            @(posedge clk);
            #1 cyc++;
            if (!m_busy) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) begin
            check("exec_timeout", 0, 1);
            finish_run();
        end
        model_apply(op, dst, src, data & m_mask);
        check("in_consumed", hs, (op != 7 && src == 0) ? 1 : 0);
        if (op == 7 || (dst != 0 && src != 0)) check("exec_cycles", cyc, 1);
        else if (dst != 0) check("exec_cycles", cyc, in_delay + 1);
        check("acc", m_acc, m_regs[1][11:0]);
        check("flag_c", m_flag_c, m_c[0]);
        check("flag_z", m_flag_z, m_z[0]);
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) begin
            run_inst($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                     longint'($urandom), $urandom_range(0, 3), -1);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("drain_queue", exp_q.size(), 0);
        check("drain_valid", m_out_valid, 0);
    endtask

    initial begin
        #500000;
        check("watchdog", 0, 1);
        finish_run();
    end

    initial begin
        // 8-bit core, eight registers.
        cfg = 1'b0;
        m_mask = 64'hFF;
        m_nregs = 8;
        do_reset();
        run_inst(0, 1, 0, 'h7F, 0, -1);
        run_inst(1, 1, 1, 0, 0, -1);
        check("add_2a", m_acc, 'hFE);
        run_inst(0, 1, 0, 'hFF, 1, -1);
        run_inst(0, 2, 0, 'h01, 0, -1);
        run_inst(1, 1, 2, 0, 0, -1);
        check("carry_chain_add", {m_acc, m_flag_c, m_flag_z}, {12'h000, 2'b11});
        run_inst(6, 1, 2, 0, 0, -1);
        check("carry_chain_adc", {m_acc, m_flag_c}, {12'h002, 1'b0});
        run_inst(2, 1, 2, 0, 0, -1);
        check("carry_chain_sub", {m_acc, m_flag_c}, {12'h001, 1'b0});
        run_inst(2, 3, 1, 0, 0, -1);
        check("sub_self_z", m_flag_z, 1);
        run_inst(0, 2, 0, 'h3C, 5, -1);
        run_inst(7, 0, 0, 'h55, 0, -1);
        run_inst(0, 1, 0, 'h11, 0, -1);
        run_inst(0, 0, 1, 0, 0, 99);
        check("bp_first", {m_out_valid, m_out_data}, {1'b1, 12'h011});
        run_inst(0, 0, 2, 0, 0, 4);
        check("bp_second", {m_out_valid, m_out_data}, {1'b1, 12'h03C});
        run_inst(0, 0, 3, 0, 0, -1);
        run_random(150);
        drain();

        // 12-bit core, five registers: indices 5..7 are out of range.
        cfg = 1'b1;
        m_mask = 64'hFFF;
        m_nregs = 5;
        do_reset();
        run_inst(0, 1, 0, 'hFFF, 0, -1);
        run_inst(0, 2, 0, 'h001, 0, -1);
        run_inst(1, 1, 2, 0, 0, -1);
        check("w12_wrap", {m_acc, m_flag_c, m_flag_z}, {12'h000, 2'b11});
        run_inst(0, 1, 0, 'h005, 0, -1);
        run_inst(1, 7, 1, 0, 0, -1);
        check("dst_oob_flags", {m_acc, m_flag_c, m_flag_z}, {12'h005, 2'b00});
        run_inst(0, 1, 6, 0, 0, -1);
        check("src_oob_zero", m_acc, 0);
        run_random(120);
        drain();

        // Reset in the middle of a stalled instruction with a beat still pending.
        run_inst(0, 2, 0, 'h0AB, 0, -1);
        run_inst(0, 1, 0, 'h123, 0, -1);
        run_inst(0, 0, 1, 0, 0, 99);
        inst_valid = 1'b1;
        inst_op = 3'd0;
        inst_dst = 3'd2;
        inst_src = 3'd0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 inst_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("midrst_busy_before", m_busy, 1);
        rst_n = 1'b0;
        #1 check("midrst_outputs", {m_busy, m_in_ready, m_out_valid, m_flag_c, m_flag_z}, 0);
        check("midrst_acc", m_acc, 0);
        check("midrst_out_data", m_out_data, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_inst(0, 0, 2, 0, 0, -1);
        drain();

        finish_run();
    end
endmodule
